// File: rtl/gate_test_sequencer_if.sv
// Bundles the sequencer's control, status and gate-facing signals.
//   start, abort  : sweep control into the sequencer
//   dut_y         : gate-under-test output fed back to the sequencer
//   stim          : registered gate input vector
//   busy, done    : sweep-in-progress level / one-cycle completion pulse
//   pass          : last completed sweep had no mismatches
//   fail_count    : mismatches in current/last sweep (N_IN+1 bits)
//   first_fail    : vector of the first mismatch
// N_IN must match the N_IN of the gate_test_sequencer it is connected to.
interface gate_test_sequencer_if #(
  parameter int N_IN = 1
);
  logic            start;
  logic            abort;
  logic            dut_y;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   fail_count;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, abort, dut_y,
    input  stim, busy, done, pass, fail_count, first_fail
  );

  modport slave (
    input  start, abort, dut_y,
    output stim, busy, done, pass, fail_count, first_fail
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Self-check controller for a 1..4-input combinational gate. Steps stim through
// every vector 0 .. 2**N_IN-1, holds each for SETTLE cycles, then samples dut_y
// and compares it with EXPECT[stim]. Reports pass, mismatch count and the first
// failing vector.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : gate_test_sequencer_if.slave (start/abort/dut_y in;
//          stim/busy/done/pass/fail_count/first_fail out)
module gate_test_sequencer #(
  parameter int                  N_IN   = 1,
  parameter int                  SETTLE = 2,
  parameter logic [2**N_IN-1:0]  EXPECT = 2'b01
) (
  input  logic                   clk,
  input  logic                   rst,
  gate_test_sequencer_if.slave   bus
);

  localparam int              CW       = $clog2(SETTLE) + 1;
  localparam int              FW       = N_IN + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fc_q, fc_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      fc_q    <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    ff_d    = ff_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE: begin
        // Results and stim are held here; they are cleared only when a new
        // sweep is actually accepted.
        if (bus.start) begin
          state_d = S_SETTLE;
          stim_d  = '0;
          cnt_d   = '0;
          fc_d    = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
        end
      end

      S_SETTLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          stim_d  = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_CHECK: begin
        cnt_d = '0;
        // abort wins over the comparison: no count update on an aborted check
        if (bus.abort) begin
          state_d = S_IDLE;
          stim_d  = '0;
          pass_d  = 1'b0;
        end else begin
          if (bus.dut_y != EXPECT[stim_q]) begin
            fc_d = fc_q + FW'(1);
            if (fc_q == '0) ff_d = stim_q;
          end
          if (stim_q == '1) begin
            state_d = S_DONE;
          end else begin
            stim_d  = stim_q + N_IN'(1);
            state_d = S_SETTLE;
          end
        end
      end

      S_DONE: begin
        pass_d  = (fc_q == '0);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign bus.done       = (state_q == S_DONE);
  assign bus.pass       = pass_q;
  assign bus.fail_count = fc_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   mode1  = 0;  // 0: correct NOT, 1: stuck-at-1, 2: buffer
  int   mode2  = 0;  // 0: correct AND, 1: OR

  always #5 clk = ~clk;

  gate_test_sequencer_if #(.N_IN(1)) bus1 ();
  gate_test_sequencer_if #(.N_IN(2)) bus2 ();

  gate_test_sequencer #(.N_IN(1), .SETTLE(2), .EXPECT(2'b01)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  gate_test_sequencer #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1000)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always_comb begin
    case (mode1)
      0:       bus1.dut_y = ~bus1.stim[0];
      1:       bus1.dut_y = 1'b1;
      default: bus1.dut_y = bus1.stim[0];
    endcase
  end

  always_comb bus2.dut_y = (mode2 == 0) ? (&bus2.stim) : (|bus2.stim);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on dut1 (edge 0) and return the edge number at which done is seen.
  task automatic sweep1(output int edge_no);
    edge_no = -1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (bus1.done) begin
        edge_no = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0;
    tick(); tick();
    checks++;
    if ({bus1.stim, bus1.busy, bus1.done, bus1.pass, bus1.fail_count, bus1.first_fail} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: got stim=%0d busy=%0b done=%0b pass=%0b fc=%0d ff=%0d want all 0",
               bus1.stim, bus1.busy, bus1.done, bus1.pass, bus1.fail_count, bus1.first_fail);
    end
    checks++;
    if ({bus2.stim, bus2.busy, bus2.done, bus2.pass, bus2.fail_count, bus2.first_fail} !== '0) begin
      errors++;
      $display("FAIL reset_dut2: got stim=%0d busy=%0b done=%0b pass=%0b fc=%0d ff=%0d want all 0",
               bus2.stim, bus2.busy, bus2.done, bus2.pass, bus2.fail_count, bus2.first_fail);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_not_pass();
    logic [0:0] stim_at [0:6];
    int         done_edge;
    mode1 = 0;
    done_edge = -1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    stim_at[0] = bus1.stim;
    checks++;
    if (bus1.busy !== 1'b1) begin
      errors++; $display("FAIL not_busy_after_start: got %0b want 1", bus1.busy);
    end
    for (int e = 1; e <= 6; e++) begin
      tick();
      stim_at[e] = bus1.stim;
      if (bus1.done && done_edge < 0) done_edge = e;
    end
    checks++;
    if ({stim_at[0], stim_at[2], stim_at[3], stim_at[5]} !== 4'b0011) begin
      errors++;
      $display("FAIL not_stim_seq: got e0=%0d e2=%0d e3=%0d e5=%0d want 0 0 1 1",
               stim_at[0], stim_at[2], stim_at[3], stim_at[5]);
    end
    checks++;
    if (done_edge !== 6) begin
      errors++; $display("FAIL not_done_edge: got %0d want 6", done_edge);
    end
    tick();
    checks++;
    if (bus1.pass !== 1'b1 || bus1.fail_count !== 2'd0 || bus1.done !== 1'b0) begin
      errors++;
      $display("FAIL not_result: got pass=%0b fc=%0d done=%0b want 1 0 0",
               bus1.pass, bus1.fail_count, bus1.done);
    end
  endtask

  task automatic test_stuck1();
    int done_edge;
    mode1 = 1;
    sweep1(done_edge);
    tick();
    checks++;
    if (done_edge !== 6 || bus1.pass !== 1'b0 || bus1.fail_count !== 2'd1 || bus1.first_fail !== 1'b1) begin
      errors++;
      $display("FAIL stuck1: got edge=%0d pass=%0b fc=%0d ff=%0d want 6 0 1 1",
               done_edge, bus1.pass, bus1.fail_count, bus1.first_fail);
    end
  endtask

  task automatic test_buffer();
    int done_edge;
    mode1 = 2;
    sweep1(done_edge);
    tick();
    checks++;
    if (done_edge !== 6 || bus1.pass !== 1'b0 || bus1.fail_count !== 2'd2 || bus1.first_fail !== 1'b0) begin
      errors++;
      $display("FAIL buffer: got edge=%0d pass=%0b fc=%0d ff=%0d want 6 0 2 0",
               done_edge, bus1.pass, bus1.fail_count, bus1.first_fail);
    end
    // results and stim hold while idle
    tick(); tick();
    checks++;
    if (bus1.fail_count !== 2'd2 || bus1.stim !== 1'b1 || bus1.busy !== 1'b0) begin
      errors++;
      $display("FAIL buffer_hold: got fc=%0d stim=%0d busy=%0b want 2 1 0",
               bus1.fail_count, bus1.stim, bus1.busy);
    end
  endtask

  task automatic test_abort();
    int done_seen;
    int done_edge;
    mode1 = 2;  // vector 0 would mismatch if the aborted check were counted
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    tick(); tick();           // edges 1,2: now in CHECK of vector 0
    bus1.abort = 1'b1;
    tick();                   // edge 3
    bus1.abort = 1'b0;
    checks++;
    if (bus1.busy !== 1'b0 || bus1.stim !== 1'b0 || bus1.done !== 1'b0 ||
        bus1.pass !== 1'b0 || bus1.fail_count !== 2'd0) begin
      errors++;
      $display("FAIL abort_state: got busy=%0b stim=%0d done=%0b pass=%0b fc=%0d want 0 0 0 0 0",
               bus1.busy, bus1.stim, bus1.done, bus1.pass, bus1.fail_count);
    end
    done_seen = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (bus1.done || bus1.busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", done_seen);
    end
    mode1 = 0;
    sweep1(done_edge);
    tick();
    checks++;
    if (done_edge !== 6 || bus1.pass !== 1'b1 || bus1.fail_count !== 2'd0) begin
      errors++;
      $display("FAIL abort_rerun: got edge=%0d pass=%0b fc=%0d want 6 1 0",
               done_edge, bus1.pass, bus1.fail_count);
    end
    bus1.abort = 1'b1;        // abort while idle must not disturb results
    tick();
    bus1.abort = 1'b0;
    tick();
    checks++;
    if (bus1.pass !== 1'b1 || bus1.busy !== 1'b0 || bus1.stim !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got pass=%0b busy=%0b stim=%0d want 1 0 1",
               bus1.pass, bus1.busy, bus1.stim);
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt;
    int done_edge;
    int seen;
    mode1 = 0;
    done_cnt = 0;
    done_edge = -1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      bus1.start = (e == 2 || e == 4 || e == 7);  // edge 7 falls in DONE
      tick();
      bus1.start = 1'b0;
      if (bus1.done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
    end
    checks++;
    if (done_cnt !== 1 || done_edge !== 6) begin
      errors++;
      $display("FAIL start_ignored: got %0d done pulses first at edge %0d want 1 at 6",
               done_cnt, done_edge);
    end
    checks++;
    if (bus1.busy !== 1'b0 || bus1.pass !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_idle: got busy=%0b pass=%0b want 0 1", bus1.busy, bus1.pass);
    end

    // synchronous reset in the middle of a sweep
    mode1 = 2;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    tick(); tick(); tick();   // edge 3: vector 0 checked, mismatch counted
    checks++;
    if (bus1.fail_count !== 2'd1 || bus1.stim !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got fc=%0d stim=%0d want 1 1", bus1.fail_count, bus1.stim);
    end
    rst = 1'b1;
    tick();                   // edge 4
    rst = 1'b0;
    checks++;
    if ({bus1.stim, bus1.busy, bus1.done, bus1.pass, bus1.fail_count, bus1.first_fail} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got stim=%0d busy=%0b done=%0b pass=%0b fc=%0d ff=%0d want all 0",
               bus1.stim, bus1.busy, bus1.done, bus1.pass, bus1.fail_count, bus1.first_fail);
    end
    seen = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (bus1.done || bus1.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_no_done: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_and4();
    logic [1:0] stim_at [0:8];
    int         done_edge;
    mode2 = 0;
    done_edge = -1;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    stim_at[0] = bus2.stim;
    for (int e = 1; e <= 8; e++) begin
      tick();
      stim_at[e] = bus2.stim;
      if (bus2.done && done_edge < 0) done_edge = e;
    end
    checks++;
    if ({stim_at[0], stim_at[2], stim_at[4], stim_at[6], stim_at[8]} !== 10'b00_01_10_11_11) begin
      errors++;
      $display("FAIL and_stim_seq: got %0d %0d %0d %0d %0d want 0 1 2 3 3",
               stim_at[0], stim_at[2], stim_at[4], stim_at[6], stim_at[8]);
    end
    checks++;
    if (done_edge !== 8) begin
      errors++; $display("FAIL and_done_edge: got %0d want 8", done_edge);
    end
    tick();
    checks++;
    if (bus2.pass !== 1'b1 || bus2.fail_count !== 3'd0) begin
      errors++;
      $display("FAIL and_result: got pass=%0b fc=%0d want 1 0", bus2.pass, bus2.fail_count);
    end

    // OR gate in place of AND: vectors 1 and 2 mismatch
    mode2 = 1;
    done_edge = -1;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (bus2.done) begin
        done_edge = e;
        break;
      end
    end
    tick();
    checks++;
    if (done_edge !== 8 || bus2.pass !== 1'b0 || bus2.fail_count !== 3'd2 || bus2.first_fail !== 2'd1) begin
      errors++;
      $display("FAIL or_as_and: got edge=%0d pass=%0b fc=%0d ff=%0d want 8 0 2 1",
               done_edge, bus2.pass, bus2.fail_count, bus2.first_fail);
    end
  endtask

  initial begin
    test_reset();
    test_not_pass();
    test_stuck1();
    test_buffer();
    test_abort();
    test_start_ignored();
    test_and4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
